addsub_share_arbiter: RTL and testbench

//  Shares one 32-bit ripple add/sub unit (fullAdder32b, cin = subtract) between NREQ requesters.

---
 rtl/addsub_share_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_addsub_share_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_share_arbiter.sv
// Purpose : round-robin share of one 32-bit ripple add/sub unit among NREQ requesters, results queued in order.
// Latency : result visible at the response head one cycle after acceptance when the response FIFO is empty.
// Backpr. : a full response FIFO withholds every grant; rsp_ready has no combinational path to req_ready.
//
// Ports
//    clk, rst                      rising-edge clock, synchronous active-high reset
//    req_valid/req_ready           per-requester handshake, req_ready is a one-hot grant
//    req_a/req_b/req_sub           packed operands, requester i in bits [32*i +: 32]; sub=1 -> A-B
//    rsp_valid/rsp_ready           response FIFO head handshake
//    rsp_id/rsp_sum/rsp_cout       head: requester index, result mod 2^32, carry (add) or borrow (sub)
//    ops_cnt                       accepted-operation counter, wraps
//    rsp_ovf                       signed overflow of the head, only with ADDSUB_ARB_OVF_EN defined
//
// Build option: define ADDSUB_ARB_OVF_EN to add the rsp_ovf port and a stored overflow bit per entry.

module addsub_share_arbiter #(
   parameter int NREQ       = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   input  logic [NREQ-1:0]      req_sub,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [31:0]          rsp_sum,
   output logic                 rsp_cout,
   output logic [15:0]          ops_cnt
`ifdef ADDSUB_ARB_OVF_EN
   ,
   output logic                 rsp_ovf
`endif
);

   localparam int IDW = $clog2(NREQ);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   // state
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [PW-1:0]  wr_q, wr_d;
   logic [PW-1:0]  rd_q, rd_d;
   logic [PW:0]    cnt_q, cnt_d;
   logic [15:0]    ops_q, ops_d;

   logic [IDW-1:0] id_mem   [FIFO_DEPTH];
   logic [31:0]    sum_mem  [FIFO_DEPTH];
   logic           cout_mem [FIFO_DEPTH];
`ifdef ADDSUB_ARB_OVF_EN
   logic           ovf_mem  [FIFO_DEPTH];
`endif

   // arbitration
   logic           found;
   logic [IDW-1:0] win;
   logic           grant;
   logic           push;
   logic           pop;

   // shared datapath
   logic [31:0]    op_a;
   logic [31:0]    op_b;
   logic           op_sub;
   logic [31:0]    op_bx;
   logic [31:0]    sum;
   logic [32:0]    carry;
   logic           cout;
   logic           ovf;

   // Rotating priority search: ptr has highest priority, then ptr+1, ... wrapping at NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   // Grant depends only on local state, never on rsp_ready, so a full FIFO blocks until a pop lands.
   assign grant = found && (cnt_q != DEPTH_C) && !rst;
   assign push  = grant;
   assign pop   = rsp_valid && rsp_ready;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = grant && (win == IDW'(i));
      end
   end

   // Operand mux into the single shared adder.
   always_comb begin
      op_a   = '0;
      op_b   = '0;
      op_sub = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IDW'(i)) begin
            op_a   = req_a[32*i +: 32];
            op_b   = req_b[32*i +: 32];
            op_sub = req_sub[i];
         end
      end
   end

   // Ripple-carry adder; subtraction is A + ~B + 1 with the +1 entering as carry-in.
   assign op_bx    = op_sub ? ~op_b : op_b;
   assign carry[0] = op_sub;

   for (genvar g = 0; g < 32; g++) begin : g_ripple
      assign sum[g]     = op_a[g] ^ op_bx[g] ^ carry[g];
      assign carry[g+1] = (op_a[g] & op_bx[g]) | (carry[g] & (op_a[g] ^ op_bx[g]));
   end

   // For subtraction the raw carry is "no borrow"; flip it so 1 means borrow.
   assign cout = carry[32] ^ op_sub;

   assign ovf = op_sub ? ((op_a[31] != op_b[31]) && (sum[31] != op_a[31]))
                       : ((op_a[31] == op_b[31]) && (sum[31] != op_a[31]));

   // next-state
   always_comb begin
      ptr_d = ptr_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ops_d = ops_q;
      if (push) begin
         ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
         wr_d  = wr_q + 1'b1;
         ops_d = ops_q + 16'd1;
      end
      if (pop) begin
         rd_d = rd_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage is cleared on reset so the head fields read 0 until the first result lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ops_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            id_mem[i]   <= '0;
            sum_mem[i]  <= '0;
            cout_mem[i] <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_mem[i]  <= 1'b0;
`endif
         end
      end else begin
         ptr_q <= ptr_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ops_q <= ops_d;
         if (push) begin
            id_mem[wr_q]   <= win;
            sum_mem[wr_q]  <= sum;
            cout_mem[wr_q] <= cout;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_mem[wr_q]  <= ovf;
`endif
         end
      end
   end

   assign rsp_valid = (cnt_q != '0);
   assign rsp_id    = id_mem[rd_q];
   assign rsp_sum   = sum_mem[rd_q];
   assign rsp_cout  = cout_mem[rd_q];
   assign ops_cnt   = ops_q;
`ifdef ADDSUB_ARB_OVF_EN
   assign rsp_ovf   = ovf_mem[rd_q];
`else
   // Overflow is only stored when the option is built in.
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_addsub_share_arbiter.sv
module tb_addsub_share_arbiter;

   localparam int NREQ = 4;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_sub;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [31:0]       rsp_sum;
   logic              rsp_cout;
   logic [15:0]       ops_cnt;
`ifdef ADDSUB_ARB_OVF_EN
   logic              rsp_ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   addsub_share_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .ops_cnt   (ops_cnt)
`ifdef ADDSUB_ARB_OVF_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_sub[i]        = s;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
         n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      end
      n_vec++; if (rsp_sum !== 32'h0 || rsp_id !== 2'd0 || rsp_cout !== 1'b0) begin n_err++; $display("FAIL reset_rsp_fields got id=%0d sum=%h cout=%b exp 0/0/0", rsp_id, rsp_sum, rsp_cout); end
      n_vec++; if (ops_cnt !== 16'd0) begin n_err++; $display("FAIL reset_ops_cnt got %0d exp 0", ops_cnt); end
      rst = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL release_req_ready got %b exp 0001", req_ready); end
      req_valid = 4'h0;
   endtask

   task automatic test_add_carry();
      set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
      req_valid = 4'b0010;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL add_grant got %b exp 0010", req_ready); end
      step();
      req_valid = 4'h0;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_err++; $display("FAIL add_head got vld=%b id=%0d exp 1/1", rsp_valid, rsp_id); end
      n_vec++; if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1) begin n_err++; $display("FAIL add_carry got sum=%h cout=%b exp 00000000/1", rsp_sum, rsp_cout); end
      n_vec++; if (ops_cnt !== 16'd1) begin n_err++; $display("FAIL add_ops_cnt got %0d exp 1", ops_cnt); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_pop got vld=%b exp 0", rsp_valid); end
   endtask

   task automatic test_sub_borrow();
      set_op(2, 32'd3, 32'd5, 1'b1);
      req_valid = 4'b0100;
      step();
      req_valid = 4'h0;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_err++; $display("FAIL sub1_head got vld=%b id=%0d exp 1/2", rsp_valid, rsp_id); end
      n_vec++; if (rsp_sum !== 32'hFFFF_FFFE || rsp_cout !== 1'b1) begin n_err++; $display("FAIL sub1_borrow got sum=%h cout=%b exp fffffffe/1", rsp_sum, rsp_cout); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      set_op(2, 32'd5, 32'd3, 1'b1);
      req_valid = 4'b0100;
      step();
      req_valid = 4'h0;
      n_vec++; if (rsp_sum !== 32'h2 || rsp_cout !== 1'b0) begin n_err++; $display("FAIL sub2_noborrow got sum=%h cout=%b exp 00000002/0", rsp_sum, rsp_cout); end
      n_vec++; if (ops_cnt !== 16'd3) begin n_err++; $display("FAIL sub_ops_cnt got %0d exp 3", ops_cnt); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_rdy;
      rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'h10 * i, i, 1'b0);
      req_valid = 4'hF; rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_rdy = 4'b0001 << (k % 4);
         n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_grant[%0d] got %b exp %b", k, req_ready, exp_rdy); end
         if (k > 0) begin
            n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k-1) % 4) || rsp_sum !== 32'h11 * ((k-1) % 4)) begin
               n_err++; $display("FAIL fair_rsp[%0d] got vld=%b id=%0d sum=%h exp 1/%0d/%h", k, rsp_valid, rsp_id, rsp_sum, (k-1) % 4, 32'h11 * ((k-1) % 4));
            end
         end
         step();
      end
      n_vec++; if (rsp_id !== 2'd3 || rsp_sum !== 32'h33) begin n_err++; $display("FAIL fair_last got id=%0d sum=%h exp 3/33", rsp_id, rsp_sum); end
      n_vec++; if (ops_cnt !== 16'd8) begin n_err++; $display("FAIL fair_ops_cnt got %0d exp 8", ops_cnt); end
      req_valid = 4'h0;
      step();
      rsp_ready = 1'b0;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL fair_drain got vld=%b exp 0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      req_valid = 4'hF; rsp_ready = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_acc0 got %b exp 0001", req_ready); end
      step();
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_acc1 got %b exp 0010", req_ready); end
      step();
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_full got %b exp 0000", req_ready); end
      n_vec++; if (ops_cnt !== 16'd10 || rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_cnt got ops=%0d id=%0d exp 10/0", ops_cnt, rsp_id); end
      step();
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_stall got %b exp 0000", req_ready); end
      rsp_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_nocomb got %b exp 0000", req_ready); end
      step();
      rsp_ready = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0100 || rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_reopen got rdy=%b id=%0d exp 0100/1", req_ready, rsp_id); end
      step();
      n_vec++; if (req_ready !== 4'b0000 || ops_cnt !== 16'd11) begin n_err++; $display("FAIL bp_one_accept got rdy=%b ops=%0d exp 0000/11", req_ready, ops_cnt); end
      req_valid = 4'h0; rsp_ready = 1'b1;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'h11) begin n_err++; $display("FAIL bp_drain1 got vld=%b id=%0d sum=%h exp 1/1/11", rsp_valid, rsp_id, rsp_sum); end
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h22) begin n_err++; $display("FAIL bp_drain2 got vld=%b id=%0d sum=%h exp 1/2/22", rsp_valid, rsp_id, rsp_sum); end
      step();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got vld=%b exp 0", rsp_valid); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_midop();
      req_valid = 4'hF; rsp_ready = 1'b0;
      step();
      rst = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_ready got %b exp 0000", req_ready); end
      step();
      rst = 1'b0; req_valid = 4'h0;
      n_vec++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 32'h0 || rsp_cout !== 1'b0) begin
         n_err++; $display("FAIL midrst_fifo got vld=%b id=%0d sum=%h cout=%b exp 0/0/0/0", rsp_valid, rsp_id, rsp_sum, rsp_cout);
      end
      n_vec++; if (ops_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_ops got %0d exp 0", ops_cnt); end
   endtask

`ifdef ADDSUB_ARB_OVF_EN
   task automatic test_ovf();
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic        vs [3];
      logic [31:0] es [3];
      logic        eo [3];
      va = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5};
      vb = '{32'h1,         32'h1,         32'd3};
      vs = '{1'b0,          1'b1,          1'b1};
      es = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
      eo = '{1'b1,          1'b1,          1'b0};
      for (int k = 0; k < 3; k++) begin
         set_op(0, va[k], vb[k], vs[k]);
         req_valid = 4'b0001; rsp_ready = 1'b0;
         step();
         req_valid = 4'h0;
         n_vec++; if (rsp_sum !== es[k] || rsp_ovf !== eo[k]) begin n_err++; $display("FAIL ovf[%0d] got sum=%h ovf=%b exp %h/%b", k, rsp_sum, rsp_ovf, es[k], eo[k]); end
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end
   endtask
`endif

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b0;
      test_reset();
      test_add_carry();
      test_sub_borrow();
      test_fairness();
      test_backpressure();
      test_reset_midop();
`ifdef ADDSUB_ARB_OVF_EN
      test_ovf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
